// File: rtl/npu_mem_arbiter_if.sv
// Bus bundle between the two PSRAM requesters (AHB slave path, NPU DMA),
// the arbiter and the PSRAM controller command/response port.
interface npu_mem_arbiter_if #(
    parameter int ADDRWIDTH = 21
);
    // Requester side
    logic [1:0]             m_req;
    logic [1:0]             m_wr;
    logic [2*ADDRWIDTH-1:0] m_addr;
    logic [63:0]            m_wdata;
    logic [1:0]             m_grant;
    logic [1:0]             m_done;
    logic [1:0]             m_err;
    logic [31:0]            m_rdata;
    logic [1:0]             m_rvalid;

    // PSRAM controller side
    logic                   mem_init_done;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic                   mem_cmd_wr;
    logic [ADDRWIDTH-1:0]   mem_cmd_addr;
    logic [31:0]            mem_wdata;
    logic [31:0]            mem_rdata;
    logic                   mem_rvalid;
    logic                   mem_done;

    // Arbiter view: it masters the PSRAM command port and answers requesters
    modport master (
        input  m_req, m_wr, m_addr, m_wdata,
        output m_grant, m_done, m_err, m_rdata, m_rvalid,
        input  mem_init_done, mem_cmd_ready, mem_rdata, mem_rvalid, mem_done,
        output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_wdata
    );

    // Environment view: requesters plus PSRAM controller
    modport slave (
        output m_req, m_wr, m_addr, m_wdata,
        input  m_grant, m_done, m_err, m_rdata, m_rvalid,
        output mem_init_done, mem_cmd_ready, mem_rdata, mem_rvalid, mem_done,
        input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_wdata
    );
endinterface

// File: rtl/npu_mem_arbiter.sv
// Two-requester round-robin arbiter in front of the PSRAM controller.
// One command is outstanding at a time: INIT waits for calibration, IDLE
// picks an owner and latches its payload, CMD presents the command until the
// controller accepts it, BUSY waits for completion or a timeout.
module npu_mem_arbiter #(
    parameter int ADDRWIDTH = 21,
    parameter int TIMEOUT   = 1023
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    npu_mem_arbiter_if.master  bus
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_CMD, S_BUSY} state_t;

    // Last BUSY count value before the abort fires (count starts at 0)
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  last_granted;
    logic                  pick;
    logic [9:0]            busy_cnt;
    logic                  busy_timeout;
    logic                  cmd_wr;
    logic [ADDRWIDTH-1:0]  cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [1:0]            done_q;
    logic [1:0]            err_q;

    function automatic logic [1:0] onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: on a tie the requester not granted last time wins
    always_comb begin
        pick = 1'b0;
        if (bus.m_req == 2'b10)
            pick = 1'b1;
        else if (bus.m_req == 2'b11)
            pick = ~last_granted;
    end

    assign busy_timeout = (busy_cnt == TO_LAST);

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    // Next-state logic; losing calibration aborts from any state
    always_comb begin
        state_nxt = state;
        if (!bus.mem_init_done) begin
            state_nxt = S_INIT;
        end else begin
            unique case (state)
                S_INIT: state_nxt = S_IDLE;
                S_IDLE: if (|bus.m_req) state_nxt = S_CMD;
                S_CMD:  if (bus.mem_cmd_ready) state_nxt = S_BUSY;
                S_BUSY: if (bus.mem_done || busy_timeout) state_nxt = S_IDLE;
                default: state_nxt = S_INIT;
            endcase
        end
    end

    // Owner, payload latch, timeout counter and completion pulses
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner        <= 1'b0;
            last_granted <= 1'b1;
            busy_cnt     <= 10'd0;
            cmd_wr       <= 1'b0;
            cmd_addr     <= '0;
            cmd_wdata    <= '0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
        end else begin
            done_q <= 2'b00;
            err_q  <= 2'b00;
            if (bus.mem_init_done) begin
                unique case (state)
                    S_IDLE: begin
                        if (|bus.m_req) begin
                            owner     <= pick;
                            cmd_wr    <= bus.m_wr[pick];
                            cmd_addr  <= pick ? bus.m_addr[2*ADDRWIDTH-1:ADDRWIDTH]
                                              : bus.m_addr[ADDRWIDTH-1:0];
                            cmd_wdata <= pick ? bus.m_wdata[63:32] : bus.m_wdata[31:0];
                        end
                    end
                    S_CMD: begin
                        if (bus.mem_cmd_ready) begin
                            last_granted <= owner;
                            busy_cnt     <= 10'd0;
                        end
                    end
                    S_BUSY: begin
                        // Completion wins over a timeout landing on the same cycle
                        if (bus.mem_done)
                            done_q <= onehot(owner);
                        else if (busy_timeout)
                            err_q <= onehot(owner);
                        else
                            busy_cnt <= busy_cnt + 10'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs: command port, grant strobe and read-data routing to the owner
    always_comb begin
        bus.mem_cmd_valid = (state == S_CMD);
        bus.mem_cmd_wr    = cmd_wr;
        bus.mem_cmd_addr  = cmd_addr;
        bus.mem_wdata     = cmd_wdata;
        bus.m_grant       = 2'b00;
        bus.m_rvalid      = 2'b00;
        bus.m_rdata       = 32'd0;
        bus.m_done        = done_q;
        bus.m_err         = err_q;
        if (state == S_CMD && bus.mem_cmd_ready && bus.mem_init_done)
            bus.m_grant = onehot(owner);
        if (state == S_CMD || state == S_BUSY) begin
            bus.m_rdata = bus.mem_rdata;
            if (bus.mem_rvalid)
                bus.m_rvalid = onehot(owner);
        end
    end
endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Directed bench for npu_mem_arbiter (ADDRWIDTH=21, TIMEOUT=8).
module tb_npu_mem_arbiter;
    localparam int AW = 21;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    npu_mem_arbiter_if #(.ADDRWIDTH(AW)) bus ();

    npu_mem_arbiter #(.ADDRWIDTH(AW), .TIMEOUT(8)) dut (
        .HCLK    (clk),
        .HRESETn (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.m_addr = {a1, a0};
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"},  64'(bus.m_grant),  64'h0);
        chk({tag, "_done"},   64'(bus.m_done),   64'h0);
        chk({tag, "_err"},    64'(bus.m_err),    64'h0);
        chk({tag, "_rvalid"}, 64'(bus.m_rvalid), 64'h0);
        chk({tag, "_valid"},  64'(bus.mem_cmd_valid), 64'h0);
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_wdata;
        logic [31:0]   beat;

        rstn              = 1'b0;
        bus.m_req         = 2'b00;
        bus.m_wr          = 2'b00;
        bus.m_addr        = '0;
        bus.m_wdata       = 64'd0;
        bus.mem_init_done = 1'b0;
        bus.mem_cmd_ready = 1'b0;
        bus.mem_rdata     = 32'hDEADBEEF;
        bus.mem_rvalid    = 1'b1;
        bus.mem_done      = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk_quiet("rst");
        chk("rst_wr",    64'(bus.mem_cmd_wr),   64'h0);
        chk("rst_addr",  64'(bus.mem_cmd_addr), 64'h0);
        chk("rst_wdata", 64'(bus.mem_wdata),    64'h0);
        chk("rst_rdata", 64'(bus.m_rdata),      64'h0);

        // Init gating: requester 0 read held while calibration is low
        rstn           = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.m_req      = 2'b01;
        set_addr(21'h00123, 21'h0);
        bus.m_wdata    = {32'h0, 32'h5A5A0001};
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("init_gate_valid", 64'(bus.mem_cmd_valid), 64'h0);
        end
        bus.mem_init_done = 1'b1;
        tick();
        #1;
        chk("init_rise1_valid", 64'(bus.mem_cmd_valid), 64'h0);
        tick();
        #1;
        chk("init_rise2_valid", 64'(bus.mem_cmd_valid), 64'h1);
        chk("init_addr",        64'(bus.mem_cmd_addr),  64'h00123);
        chk("init_wr",          64'(bus.mem_cmd_wr),    64'h0);
        chk("init_wdata",       64'(bus.mem_wdata),     64'h5A5A0001);
        chk("init_nogrant",     64'(bus.m_grant),       64'h0);

        // Accept the read, then four read-data beats to owner 0
        bus.mem_cmd_ready = 1'b1;
        #1;
        chk("rd_grant", 64'(bus.m_grant), 64'h1);
        tick();
        bus.mem_cmd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            beat           = 32'h11111111 * i;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beat;
            #1;
            chk("rd_rvalid", 64'(bus.m_rvalid), 64'h1);
            chk("rd_rdata",  64'(bus.m_rdata),  64'(beat));
            tick();
        end
        bus.mem_rvalid = 1'b0;
        #1;
        chk("rd_rvalid_off", 64'(bus.m_rvalid), 64'h0);
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        bus.m_req    = 2'b00;
        #1;
        chk("rd_done", 64'(bus.m_done), 64'h1);
        chk("rd_err",  64'(bus.m_err),  64'h0);
        tick();
        #1;
        chk("rd_done_pulse", 64'(bus.m_done), 64'h0);
        chk("rd_idle_valid", 64'(bus.mem_cmd_valid), 64'h0);

        // Round-robin from a fresh reset: both requesting, grants 0,1,0,1
        rstn = 1'b0;
        tick();
        rstn              = 1'b1;
        bus.m_req         = 2'b11;
        bus.m_wr          = 2'b10;
        set_addr(21'h00AAA, 21'h1BBBB);
        bus.m_wdata       = {32'hB1B1B1B1, 32'hA0A0A0A0};
        bus.mem_cmd_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            exp_addr  = (k % 2 == 1) ? 21'h1BBBB : 21'h00AAA;
            exp_wdata = (k % 2 == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
            chk("rr_valid", 64'(bus.mem_cmd_valid), 64'h1);
            chk("rr_grant", 64'(bus.m_grant), (k % 2 == 1) ? 64'h2 : 64'h1);
            chk("rr_addr",  64'(bus.mem_cmd_addr), 64'(exp_addr));
            chk("rr_wdata", 64'(bus.mem_wdata), 64'(exp_wdata));
            chk("rr_wr",    64'(bus.mem_cmd_wr), (k % 2 == 1) ? 64'h1 : 64'h0);
            tick();
            tick();
            tick();
            bus.mem_done = 1'b1;
            tick();
            bus.mem_done = 1'b0;
            #1;
            chk("rr_done", 64'(bus.m_done), (k % 2 == 1) ? 64'h2 : 64'h1);
        end
        bus.m_req         = 2'b00;
        bus.mem_cmd_ready = 1'b0;
        tick();

        // Backpressure: requester 1 write held for 5 cycles; payload stays put
        bus.m_req   = 2'b10;
        bus.m_wr    = 2'b10;
        set_addr(21'h00055, 21'h1ABCD);
        bus.m_wdata = {32'hCAFEF00D, 32'h0};
        tick();
        for (int i = 0; i < 5; i++) begin
            set_addr(21'h00055, 21'h00001);
            bus.m_wdata = {32'h12345678, 32'h0};
            #1;
            chk("bp_valid", 64'(bus.mem_cmd_valid), 64'h1);
            chk("bp_addr",  64'(bus.mem_cmd_addr),  64'h1ABCD);
            chk("bp_wdata", 64'(bus.mem_wdata),     64'hCAFEF00D);
            chk("bp_wr",    64'(bus.mem_cmd_wr),    64'h1);
            chk("bp_grant", 64'(bus.m_grant),       64'h0);
            tick();
        end
        bus.mem_cmd_ready = 1'b1;
        #1;
        chk("bp_grant_rdy", 64'(bus.m_grant), 64'h2);
        chk("bp_addr_rdy",  64'(bus.mem_cmd_addr), 64'h1ABCD);
        tick();
        bus.mem_cmd_ready = 1'b0;
        bus.m_req         = 2'b00;
        #1;
        chk("bp_grant_after", 64'(bus.m_grant), 64'h0);
        chk("bp_valid_after", 64'(bus.mem_cmd_valid), 64'h0);

        // Done arriving on the 8th BUSY cycle wins over the timeout
        for (int c = 1; c < 8; c++) begin
            chk("to_done_noerr", 64'(bus.m_err), 64'h0);
            tick();
            #1;
        end
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        #1;
        chk("to_done_done", 64'(bus.m_done), 64'h2);
        chk("to_done_err",  64'(bus.m_err),  64'h0);

        // Timeout with no done: owner 0 gets m_err after 8 BUSY cycles
        bus.m_req = 2'b01;
        bus.m_wr  = 2'b00;
        set_addr(21'h00777, 21'h0);
        tick();
        bus.mem_cmd_ready = 1'b1;
        #1;
        chk("to_grant", 64'(bus.m_grant), 64'h1);
        tick();
        bus.mem_cmd_ready = 1'b0;
        bus.m_req         = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk("to_noerr", 64'(bus.m_err), 64'h0);
            tick();
        end
        #1;
        chk("to_err",       64'(bus.m_err),  64'h1);
        chk("to_err_ndone", 64'(bus.m_done), 64'h0);
        chk("to_idle",      64'(bus.mem_cmd_valid), 64'h0);
        tick();
        #1;
        chk("to_err_pulse", 64'(bus.m_err), 64'h0);

        // Calibration loss in BUSY: silent abort to INIT
        bus.m_req = 2'b01;
        tick();
        bus.mem_cmd_ready = 1'b1;
        tick();
        bus.mem_cmd_ready = 1'b0;
        bus.m_req         = 2'b00;
        bus.mem_init_done = 1'b0;
        bus.mem_done      = 1'b1;
        tick();
        bus.mem_done   = 1'b0;
        bus.mem_rvalid = 1'b1;
        #1;
        chk_quiet("cal_loss");
        bus.mem_rvalid    = 1'b0;
        bus.mem_init_done = 1'b1;
        bus.m_req         = 2'b01;
        tick();
        #1;
        chk("cal_init_valid", 64'(bus.mem_cmd_valid), 64'h0);
        tick();
        #1;
        chk("cal_recover_valid", 64'(bus.mem_cmd_valid), 64'h1);

        // Reset in BUSY: silent abort, payload cleared
        bus.mem_cmd_ready = 1'b1;
        tick();
        bus.mem_cmd_ready = 1'b0;
        bus.m_req         = 2'b00;
        rstn              = 1'b0;
        bus.mem_done      = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        #1;
        chk_quiet("rst_busy");
        chk("rst_busy_addr", 64'(bus.mem_cmd_addr), 64'h0);
        rstn = 1'b1;
        tick();
        #1;
        chk("rst_busy_done", 64'(bus.m_done), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
